// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential signed divider.
// Operands are DW+1 bit two's complement; results are sign/magnitude.
package seq_divider_pkg;

  localparam int DW = 8;
  localparam int BW = $clog2(DW);

  typedef logic [DW:0]   comp2_t;
  typedef logic [DW-1:0] val_t;
  typedef logic [BW:0]   count_t;
  typedef logic          sign_t;
  typedef logic [DW:0]   prem_t;

  typedef struct packed {
    val_t  val;
    sign_t sign;
  } comp2_st;

  typedef struct packed {
    val_t  mag;
    sign_t sign;
  } div_st;

  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_SUB_SHIFT,
    D_DONE
  } div_state_t;

  localparam count_t STEP_LAST = count_t'(DW - 1);

endpackage

// File: rtl/seq_divider_comp2_to_mag.sv
// Two's complement to sign/magnitude converter.
// The most negative code has no magnitude and is flagged as illegal.
module comp2_to_mag
  import seq_divider_pkg::*;
(
  input  comp2_t  x,
  output comp2_st y,
  output logic    illegal
);

  comp2_t neg;

  // negate, then pick magnitude by sign; -2^DW maps to magnitude 0
  always_comb begin
    neg     = ~x + comp2_t'(1);
    y.sign  = x[DW];
    y.val   = x[DW] ? neg[DW-1:0] : x[DW-1:0];
    illegal = (x == {1'b1, {DW{1'b0}}});
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider, one subtract step per clock.
// Results are sign/magnitude and hold until the next division.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW:0]   dividend,
  input  logic [DW:0]   divisor,
  output logic [DW-1:0] quot_mag,
  output logic          quot_sign,
  output logic [DW-1:0] rem_mag,
  output logic          rem_sign,
  output logic          busy,
  output logic          ready,
  output logic          err
);

  div_state_t state, state_nxt;

  comp2_st dd, dv;
  logic    dd_ill, dv_ill;

  val_t   q, d;
  prem_t  r;
  count_t cnt;
  sign_t  sq, sr;

  prem_t t, r_step;
  val_t  q_step;
  logic  ge, bad;
  div_st quot_n, rem_n;

  comp2_to_mag u_dividend (
    .x       (dividend),
    .y       (dd),
    .illegal (dd_ill)
  );

  comp2_to_mag u_divisor (
    .x       (divisor),
    .y       (dv),
    .illegal (dv_ill)
  );

  assign busy  = (state != D_IDLE);
  assign ready = (state == D_DONE);

  // one restoring step plus the signed view of its result
  always_comb begin
    t           = {r[DW-1:0], q[DW-1]};
    ge          = (t >= {1'b0, d});
    r_step      = ge ? (t - {1'b0, d}) : t;
    q_step      = {q[DW-2:0], ge};
    bad         = (divisor == '0) | dd_ill | dv_ill;
    quot_n.mag  = q_step;
    quot_n.sign = sq & (q_step != '0);
    rem_n.mag   = r_step[DW-1:0];
    rem_n.sign  = sr & (r_step != '0);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= D_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      D_IDLE:      if (start) state_nxt = D_INIT;
      D_INIT:      state_nxt = bad ? D_DONE : D_SUB_SHIFT;
      D_SUB_SHIFT: if (cnt == '0) state_nxt = D_DONE;
      D_DONE:      state_nxt = D_IDLE;
    endcase
  end

  // datapath and result registers; results land on the edge into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      d         <= '0;
      r         <= '0;
      cnt       <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      quot_mag  <= '0;
      quot_sign <= 1'b0;
      rem_mag   <= '0;
      rem_sign  <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        D_IDLE: begin
          if (start) err <= 1'b0;
        end
        D_INIT: begin
          q   <= dd.val;
          d   <= dv.val;
          r   <= '0;
          sq  <= dd.sign ^ dv.sign;
          sr  <= dd.sign;
          cnt <= STEP_LAST;
          if (bad) begin
            err       <= 1'b1;
            quot_mag  <= '1;
            quot_sign <= 1'b0;
            rem_mag   <= dd.val;
            rem_sign  <= 1'b0;
          end
        end
        D_SUB_SHIFT: begin
          q   <= q_step;
          r   <= r_step;
          cnt <= cnt - count_t'(1);
          if (cnt == '0) begin
            quot_mag  <= quot_n.mag;
            quot_sign <= quot_n.sign;
            rem_mag   <= rem_n.mag;
            rem_sign  <= rem_n.sign;
          end
        end
        D_DONE: begin
        end
      endcase
    end
  end

endmodule
